// File: rtl/CPU_buffer_bus.sv
// Shared pipeline-buffer bus types, memory-stage state encoding and the
// RV32 load/store funct3 encodings used by the memory stage.
package CPU_buffer_bus;

  // Bundle leaving the EX/MEM pipeline buffer
  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
  } ex_mem_bus_t;

  // Bundle entering the MEM/WB pipeline buffer
  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
    logic        misaligned;
  } mem_wb_bus_t;

  // Data-memory access sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store alignment helper: builds byte strobes and
// replicated write data for stores, extracts and extends load data, and
// flags misaligned or unsupported access encodings.
module lsu_align
  import CPU_buffer_bus::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword lanes out of the fetched word
  always_comb begin
    sel_byte = rdata[{addr_lo, 3'b000} +: 8];
    sel_half = rdata[{addr_lo[1], 4'b0000} +: 16];
  end

  // Decode access size, build store lanes / load extension, detect misalignment
  always_comb begin
    wdata      = rs2;
    wstrb      = 4'b0000;
    load_data  = rdata;
    misaligned = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wdata = {4{rs2[7:0]}};
          wstrb = 4'b0001 << addr_lo;
        end
        F3_SH: begin
          wdata      = {2{rs2[15:0]}};
          wstrb      = 4'b0011 << addr_lo;
          misaligned = addr_lo[0];
        end
        F3_SW: begin
          wstrb      = 4'b1111;
          misaligned = (addr_lo != 2'b00);
        end
        default: misaligned = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
        F3_LH: begin
          load_data  = {{16{sel_half[15]}}, sel_half};
          misaligned = addr_lo[0];
        end
        F3_LW:  misaligned = (addr_lo != 2'b00);
        F3_LBU: load_data = {24'h000000, sel_byte};
        F3_LHU: begin
          load_data  = {16'h0000, sel_half};
          misaligned = addr_lo[0];
        end
        default: misaligned = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes non-memory instructions straight through,
// sequences aligned loads/stores over a valid/ready data-memory port and
// stalls the EX/MEM buffer until the access completes.
module mem_stage
  import CPU_buffer_bus::*;
#(
  parameter int XLEN = 32
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  ex_mem_bus_t ex_mem_bus_in,
  output mem_wb_bus_t mem_wb_bus_out,
  output logic        stall_req,
  output logic        dm_req_valid,
  input  logic        dm_req_ready,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_rsp_valid,
  input  logic [31:0] dm_rdata
);

  mem_state_e       state_q, state_d;
  logic [XLEN-1:0]  hold_q, hold_d;

  logic [31:0] align_wdata;
  logic [3:0]  align_wstrb;
  logic [31:0] align_load;
  logic        align_mis;
  logic        is_mem_access;
  logic        mem_op;
  logic        mis_access;

  lsu_align u_lsu_align (
    .funct3     (ex_mem_bus_in.funct3),
    .addr_lo    (ex_mem_bus_in.alu_result[1:0]),
    .is_store   (ex_mem_bus_in.mem_write),
    .rs2        (ex_mem_bus_in.rs2_data),
    .rdata      (hold_q),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .load_data  (align_load),
    .misaligned (align_mis)
  );

  assign is_mem_access = ex_mem_bus_in.valid &&
                         (ex_mem_bus_in.mem_read || ex_mem_bus_in.mem_write);
  assign mem_op        = is_mem_access && !align_mis;
  assign mis_access    = is_mem_access && align_mis;

  assign dm_addr  = {ex_mem_bus_in.alu_result[31:2], 2'b00};
  assign dm_we    = ex_mem_bus_in.mem_write;
  assign dm_wstrb = align_wstrb;
  assign dm_wdata = align_wdata;

  // State and load-holding register, cleared immediately by reset
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state, request, stall and MEM/WB bundle generation
  always_comb begin
    state_d                   = state_q;
    hold_d                    = hold_q;
    dm_req_valid              = 1'b0;
    stall_req                 = 1'b0;
    mem_wb_bus_out.valid      = ex_mem_bus_in.valid;
    mem_wb_bus_out.result     = ex_mem_bus_in.alu_result;
    mem_wb_bus_out.rd         = ex_mem_bus_in.rd;
    mem_wb_bus_out.reg_write  = ex_mem_bus_in.reg_write;
    mem_wb_bus_out.misaligned = 1'b0;

    if (mis_access) begin
      mem_wb_bus_out.misaligned = 1'b1;
      mem_wb_bus_out.reg_write  = 1'b0;
    end

    if (ARESETn) begin
      case (state_q)
        IDLE, REQ: begin
          if (mem_op) begin
            dm_req_valid         = 1'b1;
            stall_req            = 1'b1;
            mem_wb_bus_out.valid = 1'b0;
            if (dm_req_ready) begin
              state_d = ex_mem_bus_in.mem_write ? DONE : WAIT;
            end else begin
              state_d = REQ;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          stall_req            = 1'b1;
          mem_wb_bus_out.valid = 1'b0;
          if (dm_rsp_valid) begin
            hold_d  = dm_rdata;
            state_d = DONE;
          end
        end
        DONE: begin
          if (ex_mem_bus_in.mem_read) begin
            mem_wb_bus_out.result = align_load;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port ACLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ARESETn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ex_mem_bus_in, input, ex_mem_bus_t; fields used: valid, alu_result[31:0], rs2_data[31:0], mem_read, mem_write, funct3[2:0], rd[4:0], reg_write.
REQ-005 SHALL have port mem_wb_bus_out, output, mem_wb_bus_t; fields: valid, result[31:0], rd[4:0], reg_write, misaligned.
REQ-006 SHALL have port stall_req, output, 1, high while an access is in flight; drives stall_en of the EX/MEM buffer.
REQ-007 SHALL have ports dm_req_valid (out, 1), dm_req_ready (in, 1), dm_addr (out, 32), dm_we (out, 1), dm_wstrb (out, 4), dm_wdata (out, 32), dm_rsp_valid (in, 1), dm_rdata (in, 32).

Function
REQ-008 SHALL implement states IDLE, REQ, WAIT, DONE.
REQ-009 A memory op is ex_mem_bus_in.valid && (mem_read || mem_write) && aligned.
REQ-010 Non-memory instructions SHALL pass combinationally: result = alu_result, rd/reg_write/valid copied, stall_req = 0, misaligned = 0.
REQ-011 In IDLE or REQ with a memory op, dm_req_valid SHALL be 1, with dm_addr = {alu_result[31:2], 2'b00}.
REQ-012 Transitions: IDLE->REQ on a memory op with dm_req_ready = 0.
REQ-013 Transitions: IDLE or REQ -> WAIT on handshake for a load.
REQ-014 Transitions: IDLE or REQ -> DONE on handshake for a store.
REQ-015 Transitions: WAIT->DONE on dm_rsp_valid.
REQ-016 Transitions: DONE->IDLE unconditionally.
REQ-017 In REQ, dm_req_* SHALL stay stable until handshake.
REQ-018 dm_rsp_valid SHALL be ignored outside WAIT.
REQ-019 In WAIT, dm_rdata SHALL be captured on dm_rsp_valid into a holding register.
REQ-020 stall_req SHALL be 1 for a memory op in IDLE, REQ and WAIT, and 0 in DONE.
REQ-021 mem_wb_bus_out.valid SHALL be 0 while stall_req = 1.
REQ-022 In DONE, mem_wb_bus_out.valid SHALL be 1 and the op completes.
REQ-023 Minimum load latency SHALL be 3 cycles: handshake, response, DONE.
REQ-024 Minimum store latency SHALL be 2 cycles: handshake, DONE.
REQ-025 Store data: SB -> dm_wdata = {4{rs2[7:0]}}, dm_wstrb = 4'b0001 << addr[1:0].
REQ-026 Store data: SH -> dm_wdata = {2{rs2[15:0]}}, dm_wstrb = 4'b0011 << addr[1:0].
REQ-027 Store data: SW -> dm_wdata = rs2, dm_wstrb = 4'b1111.
REQ-028 dm_we = mem_write; dm_wstrb SHALL be 0 for loads.
REQ-029 Load extraction: the byte/half selected by addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU; LW uses the word unchanged.
REQ-030 Misalignment SHALL be flagged for LH/LHU/SH with addr[0] = 1, and for LW/SW with addr[1:0] != 0.
REQ-031 A misaligned access SHALL issue no request, keep stall_req = 0, pass through with misaligned = 1 and reg_write = 0.
REQ-032 funct3 values outside the legal load/store set SHALL be treated as misaligned.

Reset
REQ-033 ARESETn low SHALL force state = IDLE and the holding register = 0, immediately and asynchronously.
REQ-034 Reset mid-access (REQ/WAIT) SHALL abandon the access, and any later dm_rsp_valid SHALL be ignored.
REQ-035 While in reset, dm_req_valid = 0 and stall_req = 0.
REQ-036 While in reset, mem_wb_bus_out SHALL reflect pass-through of ex_mem_bus_in, which is 0 since the buffer resets.

Structure
REQ-037 ex_mem_bus_t and mem_wb_bus_t SHALL be defined in package CPU_buffer_bus.
REQ-038 The state enum and funct3 load/store encodings SHALL be defined in package CPU_buffer_bus.
REQ-039 Sub-module lsu_align (combinational: wstrb/wdata generation, load extraction, misalignment detect) SHALL be instantiated once.
REQ-040 The state machine and holding register SHALL reside in mem_stage.

Verification
REQ-041 ALU op, alu_result = 0x1234, rd = 5 -> same-cycle result 0x1234, valid = 1, stall_req = 0, dm_req_valid = 0.
REQ-042 LB at 0x103, ready = 1, rsp one cycle later with rdata = 0x80FF_FF00 -> result 0xFFFFFF80 in DONE; stall_req high exactly 2 cycles.
REQ-043 SH at 0x102, rs2 = 0xABCD -> wdata 0xABCDABCD, wstrb 4'b1100, we = 1; DONE follows the handshake cycle.
REQ-044 LW at 0x200, ready low 3 cycles -> req fields stable for 4 cycles; one handshake; LHU then yields zero-extended data.
REQ-045 LW at 0x202 -> no request, misaligned = 1, reg_write = 0, stall_req = 0.
REQ-046 ARESETn pulsed low in WAIT, then a late dm_rsp_valid -> state IDLE, rsp ignored, no valid output.
